// File: rtl/pwm_capture_pkg.sv
// Shared types and constants for the PWM period/high-time capture block.
// The optional glitch filter depth lives here so sync and top agree on it.
package pwm_capture_pkg;

  localparam int unsigned STATE_W      = 2;
  localparam int unsigned FILTER_DEPTH = 3;

  typedef enum logic [STATE_W-1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2
  } state_t;

endpackage

// File: rtl/pwm_capture_sync.sv
// Input synchronizer for the PWM pin, optionally followed by a majority-free
// stability filter (build with PWM_CAPTURE_GLITCH_FILTER_EN to enable it).
module pwm_capture_sync
  import pwm_capture_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic pwm_in,
  output logic level
);

  logic [SYNC_STAGES-1:0] sync_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], pwm_in};
    end
  end

`ifdef PWM_CAPTURE_GLITCH_FILTER_EN
  // Window takes its newest sample one stage early so the filter adds exactly two cycles.
  logic [FILTER_DEPTH-3:0] hist_q;
  logic [FILTER_DEPTH-1:0] win_c;

  assign win_c = {hist_q, sync_q[SYNC_STAGES-1], sync_q[SYNC_STAGES-2]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hist_q <= '0;
      level  <= 1'b0;
    end else begin
      hist_q <= win_c[FILTER_DEPTH-2:1];
      if (win_c == '0) begin
        level <= 1'b0;
      end else if (&win_c) begin
        level <= 1'b1;
      end
    end
  end
`else
  assign level = sync_q[SYNC_STAGES-1];
`endif

endmodule

// File: rtl/pwm_capture.sv
// PWM capture: measures period and high time of pwm_in in clk cycles and
// hands results out over a valid/ready pair. Optional filter: PWM_CAPTURE_GLITCH_FILTER_EN.
module pwm_capture
  import pwm_capture_pkg::*;
#(
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              pwm_in,
  output logic [DATA_W-1:0] period_o,
  output logic [DATA_W-1:0] high_o,
  output logic              valid_o,
  input  logic              ready_i,
  output logic              overrun_o,
  output logic              timeout_o
);

  localparam logic [DATA_W-1:0] CNT_MAX = '1;
  localparam logic [DATA_W-1:0] CNT_ONE = DATA_W'(1);

  logic              level;
  logic              level_q;
  logic              en_q;
  logic              rise_c;
  logic              fall_c;
  logic              accept_c;
  state_t            state;
  logic [DATA_W-1:0] cnt;
  logic [DATA_W-1:0] high_shadow;

  pwm_capture_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk   (clk),
    .rst   (rst),
    .pwm_in(pwm_in),
    .level (level)
  );

  assign rise_c   = level & ~level_q;
  assign fall_c   = ~level & level_q;
  assign accept_c = valid_o & ready_i;

  // Measurement FSM; a result is committed on each rise seen from LOW.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      high_shadow <= '0;
      period_o    <= '0;
      high_o      <= '0;
      valid_o     <= 1'b0;
      overrun_o   <= 1'b0;
      timeout_o   <= 1'b0;
      level_q     <= 1'b0;
      en_q        <= 1'b0;
    end else begin
      level_q <= level;
      en_q    <= en;

      if (en && !en_q) begin
        overrun_o <= 1'b0;
        timeout_o <= 1'b0;
      end

      if (accept_c) begin
        valid_o <= 1'b0;
      end

      if (!en) begin
        state   <= IDLE;
        cnt     <= '0;
        valid_o <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (rise_c) begin
              state <= HIGH;
              cnt   <= CNT_ONE;
            end
          end
          HIGH: begin
            if (cnt == CNT_MAX) begin
              timeout_o <= 1'b1;
              state     <= IDLE;
            end else if (fall_c) begin
              high_shadow <= cnt;
              cnt         <= cnt + CNT_ONE;
              state       <= LOW;
            end else begin
              cnt <= cnt + CNT_ONE;
            end
          end
          LOW: begin
            if (cnt == CNT_MAX) begin
              timeout_o <= 1'b1;
              state     <= IDLE;
            end else if (rise_c) begin
              period_o <= cnt;
              high_o   <= high_shadow;
              valid_o  <= 1'b1;
              // Acceptance in this same cycle frees the slot, so only a stalled result overruns.
              if (valid_o && !ready_i) begin
                overrun_o <= 1'b1;
              end
              cnt   <= CNT_ONE;
              state <= HIGH;
            end else begin
              cnt <= cnt + CNT_ONE;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: doc/pwm_capture.md
PWM_CAPTURE -- requirements
Module: pwm_capture

Interface
REQ-001 SHALL have parameter DATA_W, default 32, width of the count and result registers.
REQ-002 SHALL have parameter SYNC_STAGES, default 2, number of input synchronizer flops (minimum 2).
REQ-003 SHALL have port clk, input, 1, the single clock.
REQ-004 SHALL have port rst, input, 1, reset; reset is asynchronous and active-high.
REQ-005 SHALL have port en, input, 1, capture enable from the software register.
REQ-006 SHALL have port pwm_in, input, 1, asynchronous PWM waveform to measure.
REQ-007 SHALL have port period_o, output, DATA_W, measured period in clk cycles.
REQ-008 SHALL have port high_o, output, DATA_W, measured high time in clk cycles.
REQ-009 SHALL have port valid_o, output, 1, result pair available.
REQ-010 SHALL have port ready_i, input, 1, consumer accepts the result.
REQ-011 SHALL have port overrun_o, output, 1, sticky flag: an unread result was overwritten.
REQ-012 SHALL have port timeout_o, output, 1, sticky flag: the counter saturated without an edge.

Function
REQ-013 SHALL pass pwm_in through SYNC_STAGES flops, then one edge register; rise/fall detect is valid SYNC_STAGES+1 cycles after the pin changes.
REQ-014 SHALL implement FSM states IDLE, HIGH, LOW; reset state IDLE.
REQ-015 IDLE: on rise go to HIGH and load cnt=1; falls are ignored.
REQ-016 HIGH: cnt increments each cycle; on fall latch high_shadow=cnt and go to LOW.
REQ-017 LOW: cnt increments; on rise copy period_o=cnt and high_o=high_shadow, set valid_o the next cycle, reload cnt=1, go to HIGH.
REQ-018 For H cycles high and L cycles low at the synchronized input, SHALL report period_o=H+L and high_o=H.
REQ-019 Handshake: the result is consumed in a cycle where valid_o&&ready_i; valid_o deasserts the next cycle unless a new result lands in that same cycle.
REQ-020 While valid_o=1, period_o/high_o SHALL hold stable until consumed or overwritten.
REQ-021 If a new result completes while valid_o=1 and ready_i=0: overwrite the outputs, keep valid_o=1, set overrun_o.
REQ-022 If a new result completes in the same cycle as acceptance: no overrun; the new result is presented with valid_o=1.
REQ-023 If cnt reaches 2^DATA_W-1 in HIGH or LOW: saturate, set timeout_o, go to IDLE, produce no result.
REQ-024 en=0: FSM to IDLE, cnt cleared, valid_o cleared; sticky flags retained; synchronizer keeps running.
REQ-025 overrun_o and timeout_o SHALL clear only on reset or when en transitions 0->1.

Reset
REQ-026 Under rst all flops SHALL clear asynchronously: FSM=IDLE, cnt=0, period_o=0, high_o=0, valid_o=0, overrun_o=0, timeout_o=0, and synchronizer flops=0.
REQ-027 A reset mid-measurement SHALL discard the partial count; after release the first result requires two rises.

Configuration
REQ-028 Macro PWM_CAPTURE_GLITCH_FILTER_EN defined: the synchronized level SHALL be accepted only after 3 consecutive equal samples, adding 2 cycles of latency; pulses shorter than 3 cycles are ignored.
REQ-029 Macro undefined: no filter; single-cycle pulses are measured as H=1.

Structure
REQ-030 The shared package/header SHALL hold the FSM state encoding (IDLE=0, HIGH=1, LOW=2), a 2-bit state width, and the filter depth constant 3.
REQ-031 The synchronizer plus optional filter SHALL be one sub-module, pwm_capture_sync, with output level only; edge detect stays in the top module.

Verification
REQ-032 Bench: pin high 30 / low 70 cycles, repeated, ready_i=1 -> period_o=100, high_o=30, one valid pulse per period.
REQ-033 Bench: ready_i=0 across two full periods (50/50) -> overrun_o=1, outputs show the second result (100/50), valid_o stays 1.
REQ-034 Bench: DATA_W=8, pin held high 300 cycles -> timeout_o=1 at cnt=255, FSM in IDLE, no valid.
REQ-035 Bench: rst asserted mid-LOW, then 20/20 waveform -> the first valid appears after the second rise with period_o=40, high_o=20.
REQ-036 Bench: a 1-cycle high pulse every 10 cycles -> with filter, no valid; without filter, period_o=10, high_o=1.
REQ-037 Bench: valid_o&&ready_i in the same cycle a new result completes -> overrun_o stays 0 and the new values are shown.
